frame_tail_checker: RTL

Parametrised frame-tail checker for the CAN decoder. It runs on the sample-point strobe and walks the tail of every frame: CRC delimiter, ACK slot, ACK delimiter, End-Of-Frame and intermission. It reports form, ACK and overload conditions as a coded, registered event, and counts errors. It succeeds the single-purpose EOF checker: EOF and intermission lengths are parameters, ACK checking depends on transmit mode, and overload and early start-of-frame are handled.

---
 rtl/frame_tail_checker_if.sv | 29 ++
 rtl/frame_tail_checker.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/frame_tail_checker_if.sv
// Bus bundle between the CAN decoder tail stage and the frame-tail checker.
// The decoder side (master) drives the sampled bit and frame context; the
// checker side (slave) returns the coded event, pulses and error count.
interface frame_tail_checker_if #(
    parameter int CNT_W = 8
);
    logic             RX;
    logic             Tail_Start;
    logic             Tx_Mode;
    logic [2:0]       Error_Code;
    logic             Error_Valid;
    logic             Overload_Req;
    logic             Tail_Done;
    logic             SOF_Detect;
    logic             Busy;
    logic [CNT_W-1:0] Err_Count;

    modport master (
        output RX, Tail_Start, Tx_Mode,
        input  Error_Code, Error_Valid, Overload_Req, Tail_Done,
               SOF_Detect, Busy, Err_Count
    );

    modport slave (
        input  RX, Tail_Start, Tx_Mode,
        output Error_Code, Error_Valid, Overload_Req, Tail_Done,
               SOF_Detect, Busy, Err_Count
    );
endinterface

// File: rtl/frame_tail_checker.sv
// Frame-tail checker: walks CRC delimiter, ACK slot, ACK delimiter, EOF and
// intermission on the sample-point strobe, reporting coded form/ACK/overload
// events as registered one-strobe pulses and a saturating error count.
module frame_tail_checker #(
    parameter int EOF_LEN   = 7,
    parameter int IFS_LEN   = 3,
    parameter bit ACK_CHECK = 1'b1,
    parameter int CNT_W     = 8
) (
    input  logic                 SP,
    input  logic                 reset,
    frame_tail_checker_if.slave  bus
);
    localparam int MAX_LEN = (EOF_LEN > IFS_LEN) ? EOF_LEN : IFS_LEN;
    localparam int BPW     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [BPW-1:0] EOF_LAST = BPW'(EOF_LEN - 1);
    localparam logic [BPW-1:0] IFS_LAST = BPW'(IFS_LEN - 1);

    localparam logic [2:0] CODE_CRC_DEL  = 3'd1;
    localparam logic [2:0] CODE_ACK      = 3'd2;
    localparam logic [2:0] CODE_ACK_DEL  = 3'd3;
    localparam logic [2:0] CODE_EOF      = 3'd4;
    localparam logic [2:0] CODE_OVERLOAD = 3'd5;
    localparam logic [2:0] CODE_RESTART  = 3'd6;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        IDLE,
        ACK_SLOT,
        ACK_DEL,
        EOF,
        IFS
    } state_t;

    state_t           state, state_n;
    logic [BPW-1:0]   bit_pos, bit_pos_n;
    logic [2:0]       code_q, code_n;
    logic             ev_q, ev_n;
    logic             ovl_q, ovl_n;
    logic             done_q, done_n;
    logic             sof_q, sof_n;
    logic [CNT_W-1:0] cnt_q;

    // State, position and all outputs are registered on the strobe edge that
    // samples the deciding bit, so flags appear with zero extra latency.
    always_ff @(posedge SP) begin
        if (reset) begin
            state   <= IDLE;
            bit_pos <= '0;
            code_q  <= '0;
            ev_q    <= 1'b0;
            ovl_q   <= 1'b0;
            done_q  <= 1'b0;
            sof_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state   <= state_n;
            bit_pos <= bit_pos_n;
            code_q  <= code_n;
            ev_q    <= ev_n;
            ovl_q   <= ovl_n;
            done_q  <= done_n;
            sof_q   <= sof_n;
            if (ev_n && cnt_q != CNT_MAX)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    // Next-state and event decode. A Tail_Start always re-evaluates the CRC
    // delimiter, so a restart with a dominant delimiter collapses into a
    // single code-1 event instead of two pulses.
    always_comb begin
        state_n   = state;
        bit_pos_n = bit_pos;
        code_n    = code_q;
        ev_n      = 1'b0;
        ovl_n     = 1'b0;
        done_n    = 1'b0;
        sof_n     = 1'b0;

        if (bus.Tail_Start) begin
            if (state != IDLE) begin
                code_n = CODE_RESTART;
                ev_n   = 1'b1;
            end
            bit_pos_n = '0;
            if (!bus.RX) begin
                code_n  = CODE_CRC_DEL;
                ev_n    = 1'b1;
                state_n = IDLE;
            end else begin
                state_n = ACK_SLOT;
            end
        end else begin
            case (state)
                IDLE: ;
                ACK_SLOT: begin
                    bit_pos_n = '0;
                    if (ACK_CHECK && bus.Tx_Mode && bus.RX) begin
                        code_n  = CODE_ACK;
                        ev_n    = 1'b1;
                        state_n = IDLE;
                    end else begin
                        state_n = ACK_DEL;
                    end
                end
                ACK_DEL: begin
                    bit_pos_n = '0;
                    if (!bus.RX) begin
                        code_n  = CODE_ACK_DEL;
                        ev_n    = 1'b1;
                        state_n = IDLE;
                    end else begin
                        state_n = EOF;
                    end
                end
                EOF: begin
                    if (!bus.RX) begin
                        // Dominant on the final EOF bit is an overload, not a form error.
                        if (bit_pos == EOF_LAST) begin
                            code_n = CODE_OVERLOAD;
                            ovl_n  = 1'b1;
                        end else begin
                            code_n = CODE_EOF;
                            ev_n   = 1'b1;
                        end
                        bit_pos_n = '0;
                        state_n   = IDLE;
                    end else if (bit_pos == EOF_LAST) begin
                        bit_pos_n = '0;
                        state_n   = IFS;
                    end else begin
                        bit_pos_n = bit_pos + 1'b1;
                    end
                end
                IFS: begin
                    if (bit_pos == IFS_LAST) begin
                        // Dominant on the last intermission bit is the next SOF.
                        done_n    = 1'b1;
                        sof_n     = !bus.RX;
                        bit_pos_n = '0;
                        state_n   = IDLE;
                    end else if (!bus.RX) begin
                        code_n    = CODE_OVERLOAD;
                        ovl_n     = 1'b1;
                        bit_pos_n = '0;
                        state_n   = IDLE;
                    end else begin
                        bit_pos_n = bit_pos + 1'b1;
                    end
                end
                default: begin
                    bit_pos_n = '0;
                    state_n   = IDLE;
                end
            endcase
        end
    end

    assign bus.Error_Code   = code_q;
    assign bus.Error_Valid  = ev_q;
    assign bus.Overload_Req = ovl_q;
    assign bus.Tail_Done    = done_q;
    assign bus.SOF_Detect   = sof_q;
    assign bus.Busy         = (state != IDLE);
    assign bus.Err_Count    = cnt_q;
endmodule
